// File: rtl/input_port_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// input_port_unit_pkg : register offsets, bit indices and defaults
// Revision: 1.0
// ----------------------------------------------------------------------------
package input_port_unit_pkg;

  localparam logic [1:0] OFF_SW   = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_CLR  = 2'd3;

  localparam int STAT_BTN     = 0;
  localparam int STAT_PRESS   = 1;
  localparam int STAT_RELEASE = 2;
  localparam int STAT_CHANGE  = 3;

  localparam int CTRL_EN = 0;

  localparam logic [7:0]  DEF_BASE_ADDR = 8'hF0;
  localparam logic [15:0] DEF_TICK_DIV  = 16'd50000;

endpackage
`default_nettype wire

// File: rtl/input_port_unit_debounce_bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// debounce_bit : 2-flop synchronizer plus tick-sampled 3-sample debouncer
// Revision: 1.0
// ----------------------------------------------------------------------------
module debounce_bit (
  input  logic clk,
  input  logic res,
  input  logic tick,
  input  logic raw,
  output logic debounced
);

  logic       sync1;
  logic       sync2;
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (res) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      hist      <= 2'b00;
      debounced <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (tick) begin
        hist <= {hist[0], sync2};
        // Accept only when the current sample matches both previous samples.
        if ((sync2 == hist[0]) && (sync2 == hist[1])) begin
          debounced <= sync2;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_port_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// input_port_unit : memory-mapped debounced switch/button port with sticky events
// Revision: 1.0
// ----------------------------------------------------------------------------
module input_port_unit
  import input_port_unit_pkg::*;
#(
  parameter logic [7:0]       BASE_ADDR = DEF_BASE_ADDR,
  parameter int               CNT_W     = 16,
  parameter logic [CNT_W-1:0] TICK_DIV  = DEF_TICK_DIV
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] switch_in,
  input  logic       button,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  input  logic       write_enable,
  input  logic       read_enable,
  output logic [7:0] data_out,
  output logic       hit,
  output logic       irq_pending
);

  localparam logic [CNT_W-1:0] TICK_LAST = TICK_DIV - {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] prescale;
  logic             tick;
  logic [8:0]       raw;
  logic [8:0]       deb;
  logic [7:0]       sw_deb;
  logic             btn_deb;
  logic [7:0]       sw_prev;
  logic             btn_prev;
  logic [2:0]       events;
  logic [2:0]       flags;
  logic [3:0]       ctrl;
  logic [1:0]       offset;
  logic             wr_ctrl;
  logic             wr_clr;
  logic             rd_stat;
  logic [2:0]       set_mask;
  logic [2:0]       clr_mask;
  logic             unused_data_bits;

  assign tick = (prescale == TICK_LAST);

  always_ff @(posedge clk) begin
    if (res || tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign raw = {button, switch_in};

  for (genvar i = 0; i < 9; i++) begin : g_deb
    debounce_bit u_debounce_bit (
      .clk       (clk),
      .res       (res),
      .tick      (tick),
      .raw       (raw[i]),
      .debounced (deb[i])
    );
  end

  assign sw_deb  = deb[7:0];
  assign btn_deb = deb[8];

  always_ff @(posedge clk) begin
    if (res) begin
      sw_prev  <= 8'h00;
      btn_prev <= 1'b0;
    end else begin
      sw_prev  <= sw_deb;
      btn_prev <= btn_deb;
    end
  end

  // Event order matches STAT bits 3:1 = {change, release, press}.
  assign events = {|(sw_deb ^ sw_prev), ~btn_deb & btn_prev, btn_deb & ~btn_prev};

  assign hit     = (address[7:2] == BASE_ADDR[7:2]);
  assign offset  = address[1:0];
  assign wr_ctrl = hit && write_enable && (offset == OFF_CTRL);
  assign wr_clr  = hit && write_enable && (offset == OFF_CLR);
  // A concurrent write suppresses clear-on-read.
  assign rd_stat = hit && read_enable && !write_enable && (offset == OFF_STAT);

  assign set_mask = events & {3{ctrl[CTRL_EN]}};
  assign clr_mask = ({3{wr_clr}} & data_in[3:1]) | {3{rd_stat}};
  assign unused_data_bits = ^data_in[7:4];

  always_ff @(posedge clk) begin
    if (res) begin
      flags       <= 3'b000;
      ctrl        <= 4'h0;
      irq_pending <= 1'b0;
    end else begin
      flags       <= set_mask | (flags & ~clr_mask);
      irq_pending <= |(flags & ctrl[3:1]);
      if (wr_ctrl) begin
        ctrl <= data_in[3:0];
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (hit) begin
      case (offset)
        OFF_SW: data_out = sw_deb;
        OFF_STAT: begin
          data_out[STAT_BTN]     = btn_deb;
          data_out[STAT_PRESS]   = flags[0];
          data_out[STAT_RELEASE] = flags[1];
          data_out[STAT_CHANGE]  = flags[2];
        end
        OFF_CTRL: data_out = {4'h0, ctrl};
        default:  data_out = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_input_port_unit : directed scoreboard bench for input_port_unit (TICK_DIV=4)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_input_port_unit;

  logic       clk = 1'b0;
  logic       res;
  logic [7:0] switch_in;
  logic       button;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_out;
  logic       hit;
  logic       irq_pending;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic moved;
  logic seen;

  input_port_unit #(
    .BASE_ADDR (8'hF0),
    .CNT_W     (16),
    .TICK_DIV  (16'd4)
  ) dut (
    .clk          (clk),
    .res          (res),
    .switch_in    (switch_in),
    .button       (button),
    .address      (address),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .hit          (hit),
    .irq_pending  (irq_pending)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_out(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic peek(input logic [7:0] a, input string tag, input logic [7:0] v);
    @(negedge clk);
    address = a;
    #1;
    expect_val(tag, v);
    check_out(data_out);
  endtask

  task automatic chk_irq(input string tag, input logic v);
    expect_val(tag, {7'b0, v});
    check_out({7'b0, irq_pending});
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address      = a;
    data_in      = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  initial begin
    res          = 1'b1;
    switch_in    = 8'hFF;
    button       = 1'b0;
    address      = 8'hF0;
    data_in      = 8'h00;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    #1;
    expect_val("reset_sw", 8'h00);
    check_out(data_out);
    address = 8'hF1;
    #1;
    expect_val("reset_stat", 8'h00);
    check_out(data_out);
    chk_irq("reset_irq", 1'b0);

    // Debounced value must not appear before three agreeing tick samples.
    repeat (4) @(negedge clk);
    peek(8'hF0, "sw_early", 8'h00);
    repeat (10) @(negedge clk);
    peek(8'hF0, "sw_acquired", 8'hFF);

    switch_in = 8'h00;
    repeat (16) @(negedge clk);
    peek(8'hF0, "sw_cleared", 8'h00);

    moved = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      switch_in[0] = ((k / 3) % 2) == 1;
      #1;
      if (data_out[0] !== 1'b0) moved = 1'b1;
    end
    expect_val("bounce_stable", 8'h00);
    check_out({7'b0, moved});
    switch_in[0] = 1'b1;
    repeat (14) @(negedge clk);
    peek(8'hF0, "bounce_settle", 8'h01);

    wr(8'hF2, 8'h03);
    button = 1'b1;
    repeat (20) @(negedge clk);
    peek(8'hF1, "press_stat", 8'h03);
    chk_irq("press_irq", 1'b1);
    @(negedge clk);
    read_enable = 1'b1;
    #1;
    expect_val("stat_read_value", 8'h03);
    check_out(data_out);
    @(negedge clk);
    read_enable = 1'b0;
    #1;
    expect_val("stat_after_clear", 8'h01);
    check_out(data_out);
    chk_irq("irq_lag", 1'b1);
    @(negedge clk);
    #1;
    chk_irq("irq_dropped", 1'b0);

    button = 1'b0;
    repeat (20) @(negedge clk);
    peek(8'hF1, "release_stat", 8'h04);
    chk_irq("release_masked", 1'b0);
    @(negedge clk);
    read_enable = 1'b1;
    button      = 1'b1;
    seen        = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (data_out[1] === 1'b1) seen = 1'b1;
    end
    read_enable = 1'b0;
    expect_val("set_beats_clear", 8'h01);
    check_out({7'b0, seen});

    wr(8'hF2, 8'h00);
    switch_in = 8'h5A;
    repeat (20) @(negedge clk);
    peek(8'hF0, "sw_5a", 8'h5A);
    peek(8'hF1, "capture_off", 8'h01);

    wr(8'hF2, 8'h01);
    switch_in = 8'hA5;
    repeat (20) @(negedge clk);
    peek(8'hF1, "change_set", 8'h09);
    wr(8'hF2, 8'h00);
    peek(8'hF1, "disable_keeps", 8'h09);
    peek(8'hF2, "ctrl_read", 8'h00);

    @(negedge clk);
    address      = 8'hF1;
    data_in      = 8'h00;
    read_enable  = 1'b1;
    write_enable = 1'b1;
    @(negedge clk);
    read_enable  = 1'b0;
    write_enable = 1'b0;
    peek(8'hF1, "rw_no_clear", 8'h09);

    wr(8'hF3, 8'h0E);
    peek(8'hF1, "clr_write", 8'h01);
    peek(8'hF3, "clr_reads_zero", 8'h00);

    wr(8'hF2, 8'hFF);
    peek(8'hF2, "ctrl_mask", 8'h0F);
    chk_irq("irq_no_flags", 1'b0);

    @(negedge clk);
    address = 8'hF2;
    #1;
    expect_val("hit_in", 8'h01);
    check_out({7'b0, hit});
    address = 8'hEF;
    #1;
    expect_val("hit_ef", 8'h00);
    check_out({7'b0, hit});
    expect_val("data_ef", 8'h00);
    check_out(data_out);
    address = 8'hF4;
    #1;
    expect_val("hit_f4", 8'h00);
    check_out({7'b0, hit});
    expect_val("data_f4", 8'h00);
    check_out(data_out);
    wr(8'hF4, 8'h00);
    peek(8'hF2, "ctrl_unchanged", 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_port_unit.md
Name: input_port_unit

Overview:
- Memory-mapped input peripheral: the input-side counterpart of the LED/7-segment output path.
- Synchronizes and debounces the 8 board switches and the push button.
- Latches sticky press, release and change events.
- Answers processor data-memory accesses in its own address window. The memory decoder muxes `data_out` onto the processor's MDR input when `hit` is high.

Parameters:
- BASE_ADDR, 8'hF0, first byte address of the 4-register window (bits [1:0] must be 0).
- TICK_DIV, 16'd50000, clock cycles per debounce sample tick (1 ms at 50 MHz).
- CNT_W, 16, width of the tick prescaler counter.

Ports:
- clk  in  1  system clock (the same clock the processor core uses)
- res  in  1  synchronous active-high reset
- switch_in  in  8  raw asynchronous board switches
- button  in  1  raw asynchronous push button
- address  in  8  processor MAR value
- data_in  in  8  processor MDR write data
- write_enable  in  1  one-cycle write strobe
- read_enable  in  1  one-cycle read strobe; qualifies clear-on-read
- data_out  out  8  read data; 8'h00 when not hit
- hit  out  1  address is within BASE_ADDR..BASE_ADDR+3
- irq_pending  out  1  OR of the enabled sticky flags

Behaviour:
- Reset (when res=1 at a clk edge):
  - all synchronizer, debounce, sticky and control registers are 0;
  - prescaler is 0;
  - outputs: data_out=0, hit=0 (when address is out of window), irq_pending=0.
- Synchronizer:
  - each of the 9 raw inputs passes through a 2-flop chain;
  - no logic is placed between the two flops.
- Tick generation:
  - prescaler counts 0..TICK_DIV-1 and wraps;
  - `tick` is high for one cycle when the count equals TICK_DIV-1.
- Debounce, per bit:
  - on each tick, shift the synchronized value into a 2-bit history;
  - the debounced value updates to the current synchronized value only when it equals both history bits (3 agreeing consecutive tick samples);
  - otherwise the debounced value holds.
  - Latency from a clean input edge: 2 sync cycles plus 2 or 3 ticks.
- Event detection, registered one cycle after the debounced update:
  - press: debounced button goes 0->1;
  - release: debounced button goes 1->0;
  - change: any debounced switch bit differs from its previous debounced value.
- Register map (offset from BASE_ADDR), combinational read:
  - 0 SW: debounced switches; read-only, writes ignored.
  - 1 STAT: bit0 = debounced button level, bit1 = PRESS sticky, bit2 = RELEASE sticky, bit3 = CHANGE sticky, bits7:4 = 0.
  - 2 CTRL: R/W; bit0 = event capture enable, bits3:1 = irq mask for PRESS/RELEASE/CHANGE; bits7:4 read 0.
  - 3 CLR: write 1s in bits3:1 to clear the matching sticky flags; reads 8'h00.
- Sticky flags:
  - set only while CTRL.bit0=1;
  - cleared by a read of STAT (hit & read_enable & offset 1), or by a write of 1s to CLR.
  - Simultaneous set and clear in the same cycle: set wins and the flag stays 1.
- CTRL disable: clearing CTRL.bit0 does not clear existing flags.
- irq_pending: (STAT[3:1] & CTRL[3:1]) != 0; registered, so it lags the flag by 1 cycle.
- Simultaneous read_enable and write_enable: the write takes effect and the clear-on-read is suppressed.
- Reset mid-debounce: history is discarded; after reset, debounced values re-acquire from 0 via the normal rule.
- Out-of-window access: no state change; data_out=0, hit=0.

Decomposition:
- Shared package: register offsets (SW=0, STAT=1, CTRL=2, CLR=3), STAT/CTRL bit indices, default BASE_ADDR and TICK_DIV.
- One sub-module, `debounce_bit`: 2-flop synchronizer, tick-sampled 2-bit history and debounced output. Instantiated 9 times.
- Prescaler, event logic and register file stay in `input_port_unit`.

Test Plan:
All scenarios run with TICK_DIV=4.
- Reset: hold res 2 cycles with switch_in=8'hFF -> SW reads 00, STAT reads 00, irq_pending=0. After ~14 cycles SW reads FF.
- Debounce: toggle switch_in[0] every 3 cycles for 40 cycles, then hold 1 -> SW[0] never changes during the bounce; SW[0]=1 within 2+12 cycles after the hold starts.
- Press event: CTRL=8'h03, button 0->1 held -> STAT=8'h03 and irq_pending=1. Read STAT with read_enable -> next STAT=8'h01 and irq_pending drops 1 cycle later.
- Simultaneous set/clear: force the press event in the same cycle as the STAT read strobe -> STAT bit1 remains 1.
- Capture disabled: CTRL=8'h00, change switches 00->5A -> SW=5A and STAT[3]=0. Write CLR=8'h0E with flags set -> STAT[3:1]=000.
- Out-of-window: address=8'hEF or F4 -> hit=0 and data_out=00; writes to F4 leave CTRL unchanged.
